// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct constants and multiply/divide unit types.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

   // R-type opcode and the HI/LO related funct codes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] FN_MFHI   = 6'h10;
   localparam logic [5:0] FN_MTHI   = 6'h11;
   localparam logic [5:0] FN_MFLO   = 6'h12;
   localparam logic [5:0] FN_MTLO   = 6'h13;
   localparam logic [5:0] FN_MULT   = 6'h18;
   localparam logic [5:0] FN_DIV    = 6'h1a;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2,
      MD_ZDIV = 2'd3
   } md_state_t;

   // Operation kind latched at the start edge
   typedef enum logic {
      MD_OP_MULT = 1'b0,
      MD_OP_DIV  = 1'b1
   } md_op_t;

endpackage

// File: rtl/md_core_iter.sv
// Single iteration of unsigned shift-add multiply or restoring shift-subtract divide.
// Latency: combinational; the caller registers acc_nxt once per cycle.
// Backpressure: none; the caller decides when to advance.
// Ports: op selects the step, m is the multiplicand (mult) or divisor (div),
//        acc is the 2*WIDTH accumulator, acc_nxt is the accumulator after one step.
//        Mult layout: acc = {partial_high, multiplier_remaining}.
//        Div layout:  acc = {remainder, dividend_remaining/quotient_bits}.
module md_core_iter
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_t             op,
   input  logic [WIDTH-1:0]   m,
   input  logic [2*WIDTH-1:0] acc,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] part;
   logic [WIDTH:0] diff;

   always_comb begin
      sum     = '0;
      part    = '0;
      diff    = '0;
      acc_nxt = acc;
      if (op == MD_OP_MULT) begin
         // Add m into the high half when the current multiplier bit is set,
         // then shift everything right keeping the carry.
         sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
         acc_nxt = {sum, acc[WIDTH-1:1]};
      end else begin
         // Shift the next dividend bit into the remainder and try to subtract.
         // The remainder stays below m, so WIDTH+1 bits cover the shifted value.
         part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
         diff = part - {1'b0, m};
         if (!diff[WIDTH])
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV unit owning the HI/LO registers.
// Latency: start edge to done-visible cycle is WIDTH+1 cycles; divide-by-zero reports after 1 cycle.
// Backpressure: starts and HI/LO writes are ignored while busy; nothing is queued.
// Ports: MultStart/DivStart begin an operation on op_a/op_b (sampled in IDLE only),
//        HIWrite/LOWrite load wdata directly in IDLE, hi/lo are the result registers,
//        busy covers RUN and FIX, mult_done/div_done/div_by_zero are one-cycle pulses.
module mult_div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MultStart,
   input  logic             DivStart,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             HIWrite,
   input  logic             LOWrite,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             mult_done,
   output logic             div_done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   md_state_t          state, state_nxt;
   md_op_t             op_q;
   logic [WIDTH-1:0]   m_q;
   logic [2*WIDTH-1:0] acc_q, acc_nxt;
   logic               neg_lo_q, neg_hi_q;
   logic [CW-1:0]      cnt_q;

   logic               sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign sa    = op_a[WIDTH-1];
   assign sb    = op_b[WIDTH-1];
   assign mag_a = sa ? -op_a : op_a;
   assign mag_b = sb ? -op_b : op_b;

   md_core_iter #(.WIDTH(WIDTH)) u_iter (
      .op      (op_q),
      .m       (m_q),
      .acc     (acc_q),
      .acc_nxt (acc_nxt)
   );

   // Sign correction applied at FIX. For DIV, neg_lo is the quotient sign and
   // neg_hi the remainder sign (follows the dividend).
   assign prod   = neg_lo_q ? -acc_q : acc_q;
   assign fix_lo = (op_q == MD_OP_MULT) ? prod[WIDTH-1:0]
                 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
   assign fix_hi = (op_q == MD_OP_MULT) ? prod[2*WIDTH-1:WIDTH]
                 : (neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]);

   always_ff @(posedge clk) begin
      if (reset) state <= MD_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         MD_IDLE: begin
            if (MultStart)
               state_nxt = MD_RUN;
            else if (DivStart)
               state_nxt = (op_b == '0) ? MD_ZDIV : MD_RUN;
         end
         MD_RUN: begin
            busy = 1'b1;
            if (cnt_q == CW'(WIDTH-1))
               state_nxt = MD_FIX;
         end
         MD_FIX: begin
            busy      = 1'b1;
            state_nxt = MD_IDLE;
         end
         MD_ZDIV: state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi          <= '0;
         lo          <= '0;
         mult_done   <= 1'b0;
         div_done    <= 1'b0;
         div_by_zero <= 1'b0;
         cnt_q       <= '0;
         op_q        <= MD_OP_MULT;
         m_q         <= '0;
         acc_q       <= '0;
         neg_lo_q    <= 1'b0;
         neg_hi_q    <= 1'b0;
      end else begin
         mult_done   <= 1'b0;
         div_done    <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            MD_IDLE: begin
               // Multiply wins over divide; a start swallows any same-cycle HI/LO write.
               if (MultStart) begin
                  op_q     <= MD_OP_MULT;
                  m_q      <= mag_a;
                  acc_q    <= {{WIDTH{1'b0}}, mag_b};
                  neg_lo_q <= sa ^ sb;
                  neg_hi_q <= sa ^ sb;
                  cnt_q    <= '0;
               end else if (DivStart) begin
                  op_q     <= MD_OP_DIV;
                  m_q      <= mag_b;
                  acc_q    <= {{WIDTH{1'b0}}, mag_a};
                  neg_lo_q <= sa ^ sb;
                  neg_hi_q <= sa;
                  cnt_q    <= '0;
               end else begin
                  if (HIWrite) hi <= wdata;
                  if (LOWrite) lo <= wdata;
               end
            end
            MD_RUN: begin
               acc_q <= acc_nxt;
               cnt_q <= cnt_q + CW'(1);
            end
            MD_FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
               if (op_q == MD_OP_MULT) mult_done <= 1'b1;
               else                    div_done  <= 1'b1;
            end
            MD_ZDIV: begin
               div_done    <= 1'b1;
               div_by_zero <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic model.
// Latency: checks WIDTH+1 cycle result latency and 1 cycle divide-by-zero report.
// Backpressure: exercises starts and HI/LO writes issued while busy.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MultStart, DivStart, HIWrite, LOWrite;
   logic [31:0] op_a, op_b, wdata;
   logic [31:0] hi, lo;
   logic        busy, mult_done, div_done, div_by_zero;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .MultStart   (MultStart),
      .DivStart    (DivStart),
      .op_a        (op_a),
      .op_b        (op_b),
      .HIWrite     (HIWrite),
      .LOWrite     (LOWrite),
      .wdata       (wdata),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .mult_done   (mult_done),
      .div_done    (div_done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: signed arithmetic at 64 bits, so 0x80000000 / -1 simply wraps on truncation.
   task automatic model_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (is_mult) begin
         p  = sa * sb;
         eh = 32'(p >>> 32);
         el = 32'(p);
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         eh = 32'(r);
         el = 32'(q);
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h8000_0000;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h7FFF_FFFF;
         3: v = 32'($urandom_range(0, 20));
         4: v = -32'($urandom_range(1, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic run_op(input string tag, input bit ms, input bit ds,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit wr_on_start, input bit noise);
      bit          is_mult, is_div, zero, held;
      logic [31:0] eh, el;
      int          cyc, busy_cnt;
      is_mult = ms;
      is_div  = !ms && ds;
      zero    = is_div && (b == 32'd0);
      eh = m_hi;
      el = m_lo;
      if (!zero) model_op(is_mult, a, b, eh, el);

      op_a = a; op_b = b; MultStart = ms; DivStart = ds;
      if (wr_on_start) begin HIWrite = 1'b1; LOWrite = 1'b1; wdata = $urandom; end
      step();
      MultStart = 1'b0; DivStart = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
      op_a = $urandom; op_b = $urandom;
      busy_cnt = int'(busy);
      held = ({hi, lo} === {m_hi, m_lo});
      cyc = 0;
      while (!(mult_done || div_done) && cyc < 40) begin
         if (noise && cyc == 5) begin
            MultStart = 1'b1; DivStart = 1'b1; HIWrite = 1'b1; LOWrite = 1'b1; wdata = $urandom;
         end
         step();
         cyc++;
         MultStart = 1'b0; DivStart = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
         busy_cnt += int'(busy);
         if (!(mult_done || div_done) && ({hi, lo} !== {m_hi, m_lo})) held = 1'b0;
      end
      check_eq({tag, ".latency"}, 64'(cyc), zero ? 64'd1 : 64'd33);
      check_eq({tag, ".busy_cycles"}, 64'(busy_cnt), zero ? 64'd0 : 64'd33);
      check_eq({tag, ".hold"}, 64'(held), 64'd1);
      check_eq({tag, ".flags"}, {61'd0, mult_done, div_done, div_by_zero},
               {61'd0, is_mult, is_div, zero});
      m_hi = eh;
      m_lo = el;
      check_eq({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
      step();
      check_eq({tag, ".single"}, {60'd0, mult_done, div_done, div_by_zero, busy}, 64'd0);
   endtask

   task automatic write_hl(input string tag, input bit h, input bit l, input logic [31:0] d);
      HIWrite = h; LOWrite = l; wdata = d;
      step();
      HIWrite = 1'b0; LOWrite = 1'b0;
      if (h) m_hi = d;
      if (l) m_lo = d;
      check_eq(tag, {hi, lo}, {m_hi, m_lo});
   endtask

   initial begin
      int kind, dones;
      logic [31:0] a, b;
      reset = 1'b1; MultStart = 1'b0; DivStart = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
      op_a = '0; op_b = '0; wdata = '0;
      step(); step();
      reset = 1'b0;
      check_eq("reset.hilo", {hi, lo}, 64'd0);
      check_eq("reset.ctl", {60'd0, busy, mult_done, div_done, div_by_zero}, 64'd0);

      run_op("mul_7x-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0);
      check_eq("mul_7x-3.val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mul_min2", 1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0);
      check_eq("mul_min2.val", {hi, lo}, 64'h4000_0000_0000_0000);
      run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
      check_eq("div_-7/2.val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      check_eq("div_ovf.val", {hi, lo}, 64'h0000_0000_8000_0000);

      write_hl("mtlo", 0, 1, 32'h1234_5678);
      run_op("div_zero", 0, 1, 32'd5, 32'd0, 0, 0);
      check_eq("div_zero.lo", 64'(lo), 64'h1234_5678);

      run_op("both_start", 1, 1, 32'd6, 32'd4, 1, 1);
      check_eq("both_start.lo", 64'(lo), 64'd24);
      write_hl("mthi_mtlo", 1, 1, 32'hCAFE_F00D);

      // Reset in the middle of a multiply
      op_a = 32'd11; op_b = 32'd13; MultStart = 1'b1;
      step();
      MultStart = 1'b0;
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      check_eq("midreset.hilo", {hi, lo}, 64'd0);
      check_eq("midreset.ctl", {61'd0, busy, mult_done, div_done}, 64'd0);
      dones = 0;
      repeat (35) begin
         step();
         dones += int'(mult_done) + int'(div_done) + int'(busy);
      end
      check_eq("midreset.quiet", 64'(dones), 64'd0);
      run_op("post_reset_3x3", 1, 0, 32'd3, 32'd3, 0, 0);
      check_eq("post_reset_3x3.lo", 64'(lo), 64'd9);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         a = pick();
         b = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
         if ($urandom_range(0, 4) == 0) write_hl("rnd.wr", 1'($urandom), 1'($urandom), $urandom);
         run_op($sformatf("rnd%0d", i), kind != 1, kind != 0, a, b,
                1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
